uart_rx_packetizer: RTL and testbench

//  Single-clock receive-side packer for the UART peripheral. It replaces the fixed 3-byte rx combine.
//  - Collects bytes from the UART receiver (already synchronised into clk) into 24-bit payloads.
//  - Writes each payload to the peripheral rx FIFO as one packet with a byte count.
//  - Flushes partial payloads after an idle timeout or on request.
//  - Buffers one packet against rx_full back-pressure and counts dropped bytes.

---
 rtl/uart_rx_packetizer.sv | 146 ++++++++++++++
 tb/tb_uart_rx_packetizer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_packetizer.sv
// uart_rx_packetizer: packs received UART bytes into 24-bit payloads and
// writes them to the rx FIFO as {1'b0, count[1:0], 2'b00, payload[23:0]}.
// A partial payload is sent after an idle timeout or on a flush request.
// One packet is buffered against FIFO back-pressure; bytes that arrive with
// no room anywhere are dropped and counted.
module uart_rx_packetizer #(
   parameter int unsigned FLUSH_CYCLES = 104160,
   parameter int unsigned DROP_CNT_W   = 8,
   parameter int unsigned PW           = 29
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            byte_in,
   input  logic                  byte_valid,
   input  logic                  flush,
   output logic [PW-1:0]         rx_data,
   output logic                  rx_wren,
   input  logic                  rx_full,
   output logic                  overflow,
   output logic [DROP_CNT_W-1:0] drop_count,
   output logic                  idle
);

   localparam int unsigned TW = $clog2(FLUSH_CYCLES);
   localparam logic [TW-1:0] TIMER_MAX = TW'(FLUSH_CYCLES - 1);

   // Accumulator states, encoded directly by the byte count
   localparam logic [1:0] ACC_EMPTY = 2'd0;
   localparam logic [1:0] ACC_FULL  = 2'd3;

   logic [23:0]           acc_data_q, acc_data_d;
   logic [1:0]            acc_cnt_q, acc_cnt_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic                  flush_hold_q, flush_hold_d;
   logic                  pending_q, pending_d;
   logic [PW-1:0]         rx_data_q, rx_data_d;
   logic                  overflow_q, overflow_d;
   logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;
   logic                  idle_q, idle_d;

   logic acc_empty, acc_full, acc_partial;
   logic out_free, trig_full, trig_timeout, trig_flush, xfer, drop;

   // FIFO enable: registered payload, enable qualified by back-pressure and reset
   assign rx_wren = pending_q & ~rx_full & ~rst;

   // Transfer and drop decisions for this cycle
   always_comb begin
      acc_empty    = (acc_cnt_q == ACC_EMPTY);
      acc_full     = (acc_cnt_q == ACC_FULL);
      acc_partial  = ~acc_empty & ~acc_full;
      out_free     = ~pending_q | rx_wren;
      trig_full    = acc_full;
      trig_timeout = acc_partial & (timer_q == TIMER_MAX) & ~byte_valid;
      trig_flush   = (flush | flush_hold_q) & ~acc_empty;
      xfer         = (trig_full | trig_timeout | trig_flush) & out_free;
      drop         = byte_valid & acc_full & ~xfer;
   end

   // Next-state logic for accumulator, out stage and drop accounting
   always_comb begin
      acc_data_d   = acc_data_q;
      acc_cnt_d    = acc_cnt_q;
      timer_d      = timer_q;
      flush_hold_d = flush_hold_q;
      pending_d    = pending_q;
      rx_data_d    = rx_data_q;
      overflow_d   = overflow_q;
      drop_count_d = drop_count_q;

      if (xfer) begin
         // Out stage takes the old contents; a coincident byte starts a fresh payload
         rx_data_d    = PW'({1'b0, acc_cnt_q, 2'b00, acc_data_q});
         flush_hold_d = 1'b0;
         timer_d      = '0;
         if (byte_valid) begin
            acc_data_d = {16'h0000, byte_in};
            acc_cnt_d  = 2'd1;
         end else begin
            acc_data_d = '0;
            acc_cnt_d  = ACC_EMPTY;
         end
      end else begin
         // A flush that cannot be served yet is kept until the transfer happens
         if (flush && !acc_empty) begin
            flush_hold_d = 1'b1;
         end
         if (byte_valid) begin
            if (!acc_full) begin
               acc_data_d[{acc_cnt_q, 3'b000} +: 8] = byte_in;
               acc_cnt_d = acc_cnt_q + 2'd1;
               timer_d   = '0;
            end
         end else if (acc_partial && (timer_q != TIMER_MAX)) begin
            timer_d = timer_q + TW'(1);
         end
      end

      if (rx_wren) begin
         pending_d = 1'b0;
      end
      if (xfer) begin
         pending_d = 1'b1;
      end

      if (drop) begin
         overflow_d = 1'b1;
         if (drop_count_q != '1) begin
            drop_count_d = drop_count_q + DROP_CNT_W'(1);
         end
      end

      idle_d = (acc_cnt_d == ACC_EMPTY) & ~pending_d;
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_data_q   <= '0;
         acc_cnt_q    <= ACC_EMPTY;
         timer_q      <= '0;
         flush_hold_q <= 1'b0;
         pending_q    <= 1'b0;
         rx_data_q    <= '0;
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
         idle_q       <= 1'b1;
      end else begin
         acc_data_q   <= acc_data_d;
         acc_cnt_q    <= acc_cnt_d;
         timer_q      <= timer_d;
         flush_hold_q <= flush_hold_d;
         pending_q    <= pending_d;
         rx_data_q    <= rx_data_d;
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
         idle_q       <= idle_d;
      end
   end

   assign rx_data    = rx_data_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_count_q;
   assign idle       = idle_q;

endmodule

// File: tb/tb_uart_rx_packetizer.sv
// Scoreboard bench for uart_rx_packetizer: a queue-based packing model predicts
// packets and status; a negedge monitor compares whatever the DUT presents.
module tb_uart_rx_packetizer;

   localparam int unsigned FC = 16;
   localparam int unsigned DW = 8;
   localparam int unsigned PW = 29;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    byte_in;
   logic          byte_valid;
   logic          flush;
   logic [PW-1:0] rx_data;
   logic          rx_wren;
   logic          rx_full;
   logic          overflow;
   logic [DW-1:0] drop_count;
   logic          idle;

   always #5 clk = ~clk;

   uart_rx_packetizer #(
      .FLUSH_CYCLES(FC),
      .DROP_CNT_W  (DW),
      .PW          (PW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .byte_in   (byte_in),
      .byte_valid(byte_valid),
      .flush     (flush),
      .rx_data   (rx_data),
      .rx_wren   (rx_wren),
      .rx_full   (rx_full),
      .overflow  (overflow),
      .drop_count(drop_count),
      .idle      (idle)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0]    m_acc[$];
   logic [PW-1:0] exp_q[$];
   int            m_silent;
   bit            m_fmem, m_busy, m_ovf;
   int            m_drops;
   int            cyc = 0;
   bit            m_wr, m_free, m_trig;
   int            m_n;
   logic [23:0]   m_pay;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_acc.delete();
         exp_q.delete();
         m_silent = 0;
         m_fmem   = 0;
         m_busy   = 0;
         m_ovf    = 0;
         m_drops  = 0;
      end else begin
         m_n    = m_acc.size();
         m_wr   = m_busy && !rx_full;
         m_free = !m_busy || m_wr;
         m_trig = (m_n == 3)
               || (m_n > 0 && m_n < 3 && m_silent == FC - 1 && !byte_valid)
               || ((flush || m_fmem) && m_n > 0);
         if (m_wr) m_busy = 0;
         if (m_trig && m_free) begin
            m_pay = 24'h0;
            for (int i = 0; i < m_n; i++) m_pay = m_pay | (24'(m_acc[i]) << (8 * i));
            exp_q.push_back({1'b0, 2'(m_n), 2'b00, m_pay});
            m_busy   = 1;
            m_acc.delete();
            m_silent = 0;
            m_fmem   = 0;
            if (byte_valid) m_acc.push_back(byte_in);
         end else begin
            if (flush && m_n > 0) m_fmem = 1;
            if (byte_valid) begin
               if (m_n == 3) begin
                  m_ovf = 1;
                  if (m_drops < 255) m_drops++;
               end else begin
                  m_acc.push_back(byte_in);
                  m_silent = 0;
               end
            end else if (m_n > 0 && m_n < 3 && m_silent < FC - 1) begin
               m_silent++;
            end
         end
      end
   end

   // ---------------- monitor ----------------
   bit mon_en = 0;
   int wr_cnt = 0;
   int last_wr_cyc = 0;
   bit exp_wren;

   always @(negedge clk) begin
      if (mon_en) begin
         exp_wren = m_busy && !rx_full && !rst;
         chk("rx_wren", 64'(rx_wren), 64'(exp_wren));
         if (rx_wren) begin
            wr_cnt++;
            last_wr_cyc = cyc;
            chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) chk("rx_data", 64'(rx_data), 64'(exp_q.pop_front()));
         end
         chk("overflow", 64'(overflow), 64'(m_ovf));
         chk("drop_count", 64'(drop_count), 64'(m_drops));
         chk("idle", 64'(idle), 64'(m_acc.size() == 0 && !m_busy));
      end
   end

   // ---------------- stimulus ----------------
   int last_strobe = 0;
   int w0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      byte_in     = b;
      byte_valid  = 1'b1;
      last_strobe = cyc;
      tick();
      byte_valid  = 1'b0;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rate;
      int full_pct;
      rst = 1'b1; byte_in = 8'h00; byte_valid = 1'b0; flush = 1'b0; rx_full = 1'b0;
      idle_cycles(2);
      chk("reset_rx_data", 64'(rx_data), 64'd0);
      chk("reset_rx_wren", 64'(rx_wren), 64'd0);
      chk("reset_overflow", 64'(overflow), 64'd0);
      chk("reset_drop_count", 64'(drop_count), 64'd0);
      chk("reset_idle", 64'(idle), 64'd1);
      rst = 1'b0;
      mon_en = 1;

      // 1: three back-to-back bytes -> one full packet, N+2 latency
      w0 = wr_cnt;
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      w0 = w0; idle_cycles(5);
      chk("t1_writes", 64'(wr_cnt - w0), 64'd1);
      chk("t1_latency", 64'(last_wr_cyc - last_strobe), 64'd2);

      // 2: single byte then silence -> timeout write 17 cycles after strobe
      w0 = wr_cnt;
      send_byte(8'hA5);
      idle_cycles(22);
      chk("t2_writes", 64'(wr_cnt - w0), 64'd1);
      chk("t2_latency", 64'(last_wr_cyc - last_strobe), 64'd17);
      chk("t2_idle", 64'(idle), 64'd1);

      // 3: back-pressure, seven bytes -> one drop, then two writes on release
      w0 = wr_cnt;
      rx_full = 1'b1;
      for (int i = 1; i <= 7; i++) send_byte(8'(i));
      idle_cycles(2);
      chk("t3_overflow", 64'(overflow), 64'd1);
      chk("t3_drop_count", 64'(drop_count), 64'd1);
      chk("t3_no_write_while_full", 64'(wr_cnt - w0), 64'd0);
      rx_full = 1'b0;
      idle_cycles(5);
      chk("t3_writes", 64'(wr_cnt - w0), 64'd2);

      // 4: second byte exactly on the last timer cycle -> capture wins
      w0 = wr_cnt;
      send_byte(8'h5A);
      idle_cycles(15);
      send_byte(8'hC3);
      idle_cycles(15);
      chk("t4_no_early_flush", 64'(wr_cnt - w0), 64'd0);
      idle_cycles(5);
      chk("t4_writes", 64'(wr_cnt - w0), 64'd1);
      chk("t4_latency", 64'(last_wr_cyc - last_strobe), 64'd17);

      // 5: reset mid-packet discards everything
      w0 = wr_cnt;
      send_byte(8'hDE); send_byte(8'hAD);
      do_reset();
      idle_cycles(20);
      chk("t5_no_write", 64'(wr_cnt - w0), 64'd0);
      chk("t5_overflow_cleared", 64'(overflow), 64'd0);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
      idle_cycles(4);
      chk("t5_clean_packet", 64'(wr_cnt - w0), 64'd1);

      // 6: flush while empty ignored; flush after two bytes sends count 2
      w0 = wr_cnt;
      pulse_flush();
      idle_cycles(3);
      chk("t6_empty_flush", 64'(wr_cnt - w0), 64'd0);
      send_byte(8'h77); send_byte(8'h88);
      pulse_flush();
      idle_cycles(3);
      chk("t6_flush_writes", 64'(wr_cnt - w0), 64'd1);
      chk("t6_flush_latency", 64'(last_wr_cyc - last_strobe), 64'd2);

      // 7: 300 drops saturate the counter; only reset clears overflow
      rx_full = 1'b1;
      for (int i = 0; i < 306; i++) send_byte(8'($urandom));
      chk("t7_drop_sat", 64'(drop_count), 64'hFF);
      chk("t7_overflow", 64'(overflow), 64'd1);
      rx_full = 1'b0;
      idle_cycles(10);
      chk("t7_overflow_sticky", 64'(overflow), 64'd1);
      do_reset();
      chk("t7_reset_overflow", 64'(overflow), 64'd0);
      chk("t7_reset_drop", 64'(drop_count), 64'd0);

      // Randomised traffic with varying byte rate, back-pressure and flushes
      for (int seg = 0; seg < 20; seg++) begin
         rate     = $urandom_range(95, 2);
         full_pct = $urandom_range(80, 0);
         for (int c = 0; c < 200; c++) begin
            byte_valid = ($urandom_range(99, 0) < rate);
            byte_in    = 8'($urandom);
            flush      = ($urandom_range(29, 0) == 0);
            if ($urandom_range(9, 0) == 0) rx_full = ($urandom_range(99, 0) < full_pct);
            rst        = ($urandom_range(599, 0) == 0);
            if (byte_valid) last_strobe = cyc;
            tick();
         end
         byte_valid = 1'b0; flush = 1'b0; rst = 1'b0;
      end

      // Drain and confirm nothing is left outstanding
      rx_full = 1'b0;
      idle_cycles(40);
      chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
      chk("drain_idle", 64'(idle), 64'd1);

      mon_en = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
